// File: rtl/ahb_master.sv
// AHB-Lite initiator: turns a command/stream interface into pipelined SINGLE/INCR word transfers.
// Define AHB_MASTER_BURST_EN to honour cmd_len; otherwise every command is a single beat.
module ahb_master #(
    parameter int ADDR_W    = 32,
    parameter int MAX_LEN_W = 4
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [MAX_LEN_W-1:0] cmd_len,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
`ifdef AHB_MASTER_BURST_EN
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] haddr_d;
    logic [1:0]        htrans_d;
    logic              hwrite_d;
    logic [2:0]        hburst_d;
    logic              done_d;
    logic              err_d;
    logic              rd_beat;

`ifdef AHB_MASTER_BURST_EN
    // Address phases still to issue after the one currently on the bus.
    logic [MAX_LEN_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    next_addr;

    assign next_addr = haddr + ADDR_W'(4);
`else
    logic unused_len;
    assign unused_len = ^cmd_len;
`endif

    assign hsize     = 3'b010;
    assign cmd_ready = (state_q == S_IDLE);

    // Write data is taken on the same edge that accepts its address phase.
    assign wr_ready = hwrite && hready && (state_q == S_ADDR || state_q == S_BURST);

    // A read data phase finishes cleanly while in BURST or LAST with an OKAY response.
    assign rd_beat = !hwrite && hready && !hresp && (state_q == S_BURST || state_q == S_LAST);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d  = state_q;
        haddr_d  = haddr;
        htrans_d = htrans;
        hwrite_d = hwrite;
        hburst_d = hburst;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef AHB_MASTER_BURST_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d  = S_ADDR;
                    haddr_d  = cmd_addr;
                    htrans_d = HTRANS_NONSEQ;
                    hwrite_d = cmd_write;
`ifdef AHB_MASTER_BURST_EN
                    hburst_d = (cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
                    cnt_d    = cmd_len;
`else
                    hburst_d = HBURST_SINGLE;
`endif
                end
            end
            S_ADDR, S_BURST: begin
                if (state_q == S_BURST && hresp && !hready) begin
                    state_d  = S_ERR;
                    htrans_d = HTRANS_IDLE;
                end else if (hready) begin
`ifdef AHB_MASTER_BURST_EN
                    if (cnt_q == '0) begin
                        state_d  = S_LAST;
                        htrans_d = HTRANS_IDLE;
                    end else begin
                        state_d  = S_BURST;
                        haddr_d  = next_addr;
                        // Slaves may not see a SEQ beat cross a 1 KB page, so restart with NONSEQ.
                        htrans_d = (next_addr[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                        cnt_d    = cnt_q - MAX_LEN_W'(1);
                    end
`else
                    state_d  = S_LAST;
                    htrans_d = HTRANS_IDLE;
`endif
                end
            end
            S_LAST: begin
                if (hresp && !hready) begin
                    state_d = S_ERR;
                end else if (hready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ERR: begin
                if (hready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= S_IDLE;
            haddr    <= '0;
            htrans   <= HTRANS_IDLE;
            hwrite   <= 1'b0;
            hburst   <= HBURST_SINGLE;
            hwdata   <= 32'd0;
            rd_data  <= 32'd0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef AHB_MASTER_BURST_EN
            cnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            haddr    <= haddr_d;
            htrans   <= htrans_d;
            hwrite   <= hwrite_d;
            hburst   <= hburst_d;
            rd_valid <= rd_beat;
            done     <= done_d;
            err      <= err_d;
`ifdef AHB_MASTER_BURST_EN
            cnt_q    <= cnt_d;
`endif
            if (wr_ready) begin
                hwdata <= wr_data;
            end
            if (rd_beat) begin
                rd_data <= hrdata;
            end
        end
    end

endmodule

// File: doc/ahb_master.md
# ahb_master

Single-layer AHB-Lite initiator that turns a simple command/stream interface into pipelined AHB transfers. It is the bus-side counterpart to the team's register-file AHB slaves. It sits between a local controller (DMA engine, test sequencer) and the AHB interconnect, whose decoder generates `hsel`. It issues SINGLE and INCR bursts of 32-bit words, overlaps address and data phases, honours `hready` wait states and aborts on an `hresp` error.

## Interface
- `ADDR_W`, 32, address width; `haddr` and `cmd_addr` width.
- `MAX_LEN_W`, 4, width of `cmd_len`; bursts are 1..2^MAX_LEN_W beats.
- `hclk` in 1: single clock; everything is rising-edge.
- `hresetn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block is idle and accepts a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: start byte address; bits [1:0] must be 0.
- `cmd_len` in MAX_LEN_W: beats minus one.
- `wr_data` in 32: write beat data, sampled when `wr_ready`=1.
- `wr_ready` out 1: one-cycle pulse; `wr_data` is consumed this cycle.
- `rd_data` out 32: read beat data.
- `rd_valid` out 1: one-cycle pulse per completed read beat.
- `done` out 1: one-cycle pulse when the command finishes.
- `err` out 1: qualifies `done`; 1 = an error response was received.
- `haddr` out ADDR_W, `htrans` out 2, `hwrite` out 1, `hsize` out 3 (fixed 3'b010), `hburst` out 3, `hwdata` out 32: AHB master outputs.
- `hrdata` in 32, `hready` in 1, `hresp` in 1: AHB slave response inputs.

## Operation
- **States:**
  - IDLE: `cmd_ready`=1.
  - ADDR: address phase of the first beat (NONSEQ) in flight.
  - BURST: address of beat n+1 overlaps the data phase of beat n.
  - LAST: final data phase only; `htrans`=IDLE.
  - ERR: second cycle of the error response.
- **Command accept:** IDLE -> ADDR on `cmd_valid`&&`cmd_ready`. Addr, write and len are latched, the beat counter is loaded with `cmd_len`, and `cmd_ready` drops the next cycle.
- **Bus encoding:**
  - First beat: `htrans`=NONSEQ (2'b10).
  - Subsequent beats: SEQ (2'b11), `haddr` += 4 per accepted address phase.
  - `hburst` = SINGLE (3'b000) when len=0, else INCR (3'b001).
- **Address acceptance:** an address phase is accepted on a cycle with `hready`=1. Outputs hold while `hready`=0.
- **1 KB boundary:** a beat whose address has bits [9:0]=0 and is not the first beat is issued as NONSEQ, not SEQ.
- **Write data:**
  - `wr_ready` pulses in the cycle the beat's address phase is accepted.
  - `hwdata` <= `wr_data` on that edge and is held until its data phase completes.
- **Read data:** `rd_valid`=1 and `rd_data`=`hrdata`, registered, the cycle after a read data phase completes (`hready`=1, `hresp`=0).
- **Completion:** LAST -> IDLE on `hready`=1, with `done`=1 and `err`=0 the following cycle.
- **Error:**
  - Trigger: `hresp`=1 with `hready`=0 in a data phase.
  - Response: next cycle `htrans`=IDLE (any pending address is cancelled) and the FSM enters ERR.
  - On `hready`=1: IDLE, then `done`=1 and `err`=1.
  - No further `rd_valid` or `wr_ready` is issued for the command.
- **Reset values:** `haddr`=0, `htrans`=IDLE, `hwrite`=0, `hburst`=0, `hsize`=3'b010, `hwdata`=0, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `done`=0, `err`=0, `cmd_ready`=1.
- **Reset mid-burst:** outputs return to reset values immediately; the command is lost with no `done`.

## Timing
- Command latency: accept edge -> NONSEQ on the bus in the next cycle.
- Zero-wait N-beat burst: N+1 bus cycles from NONSEQ to the end of the last data phase. `done` follows one cycle after that.
- Each `hready`=0 cycle stretches the current phase by one cycle; both phases stall together.
- Back-to-back commands are allowed: `cmd_ready` reasserts in the cycle `done` pulses. The bus shows at least one IDLE cycle between commands.

## Configuration
- `AHB_MASTER_BURST_EN` defined:
  - `cmd_len` is honoured; INCR bursts with SEQ beats as above.
- `AHB_MASTER_BURST_EN` undefined:
  - `cmd_len` is ignored and every command is one beat.
  - `hburst` is always SINGLE, `htrans` is only NONSEQ/IDLE, and the beat counter and 1 KB logic are removed.

## Test plan
- **Single write:** addr 0x14, data 0xDEADBEEF, no wait states -> NONSEQ/SINGLE at 0x14, `hwdata`=0xDEADBEEF in the next cycle, `done`=1 with `err`=0.
- **Burst read:** len=3 at 0x20, slave returns 1,2,3,4 -> haddr 0x20/24/28/2C (NONSEQ, SEQ, SEQ, SEQ), four `rd_valid` pulses with data 1..4, then `done`.
- **Wait states:** 2-cycle `hready`=0 on beat 2 of a 4-beat write -> `haddr`/`hwdata` stable during the stall, exactly 4 `wr_ready` pulses.
- **1 KB crossing:** len=1 at 0x3FC -> beat 2 at 0x400 issued as NONSEQ.
- **Error:** `hresp`=1 on beat 1 of a 4-beat read -> `htrans`=IDLE next cycle, no `rd_valid` for that beat, `done`=1 with `err`=1.
- **Reset mid-burst:** `hresetn` low in beat 2 -> `htrans`=IDLE immediately, `cmd_ready`=1 after release, no `done`.
